// File: rtl/fetch_sequencer_if.sv
// Instruction-memory read port and decode handshake bundle for fetch_sequencer.
// master = sequencer side, slave = memory/decode side.
interface fetch_sequencer_if #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned INSTR_W = 32
);
  logic               im_req;
  logic [ADDR_W-1:0]  im_addr;
  logic [INSTR_W-1:0] im_rdata;
  logic               instr_valid;
  logic               instr_ready;
  logic [INSTR_W-1:0] instr_out;
  logic [ADDR_W-1:0]  instr_pc;

  modport master (
    output im_req, im_addr, instr_valid, instr_out, instr_pc,
    input  im_rdata, instr_ready
  );

  modport slave (
    input  im_req, im_addr, instr_valid, instr_out, instr_pc,
    output im_rdata, instr_ready
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Single-outstanding instruction fetch sequencer: PC, fixed-latency IM read, IR handshake, branch redirect.
// Optional perf counters (fetch_count/flush_count) built when FETCH_PERF_COUNT_EN is defined.
module fetch_sequencer #(
  parameter int unsigned       ADDR_W   = 8,
  parameter int unsigned       INSTR_W  = 32,
  parameter int unsigned       MEM_LAT  = 1,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int unsigned       PC_STEP  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_run,
  input  logic              i_branch_valid,
  input  logic [ADDR_W-1:0] i_branch_target,
  fetch_sequencer_if.master bus,
  output logic [ADDR_W-1:0] o_pc_out,
  output logic              o_busy,
  output logic              o_pc_wrap
`ifdef FETCH_PERF_COUNT_EN
  ,
  output logic [15:0]       o_fetch_count,
  output logic [7:0]        o_flush_count
`endif
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

  localparam logic [2:0] LAT_LOAD = 3'(MEM_LAT - 1);

  state_t             r_state;
  state_t             w_next_state;
  logic [ADDR_W-1:0]  r_pc;
  logic [INSTR_W-1:0] r_instr;
  logic [ADDR_W-1:0]  r_instr_pc;
  logic               r_valid;
  logic               r_wrap;
  logic [2:0]         r_cnt;
  logic [ADDR_W:0]    w_pc_sum;

  // Extra top bit is the carry out, i.e. the wrap indication.
  assign w_pc_sum = {1'b0, r_pc} + (ADDR_W+1)'(PC_STEP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    if (i_branch_valid) begin
      w_next_state = i_run ? REQ : IDLE;
    end else begin
      case (r_state)
        IDLE:    if (i_run) w_next_state = REQ;
        REQ:     w_next_state = WAIT;
        WAIT:    if (r_cnt == '0) w_next_state = HOLD;
        HOLD:    if (bus.instr_ready) w_next_state = i_run ? REQ : IDLE;
        default: w_next_state = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc       <= RESET_PC;
      r_instr    <= '0;
      r_instr_pc <= '0;
      r_valid    <= 1'b0;
      r_wrap     <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_wrap <= 1'b0;
      if (i_branch_valid) begin
        // Redirect wins over capture and accept; any in-flight read is dropped.
        r_pc    <= i_branch_target;
        r_valid <= 1'b0;
        r_cnt   <= '0;
      end else begin
        case (r_state)
          REQ: r_cnt <= LAT_LOAD;
          WAIT: begin
            if (r_cnt == '0) begin
              r_instr    <= bus.im_rdata;
              r_instr_pc <= r_pc;
              r_valid    <= 1'b1;
            end else begin
              r_cnt <= r_cnt - 3'd1;
            end
          end
          HOLD: begin
            if (bus.instr_ready) begin
              r_pc    <= w_pc_sum[ADDR_W-1:0];
              r_wrap  <= w_pc_sum[ADDR_W];
              r_valid <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

`ifdef FETCH_PERF_COUNT_EN
  logic [15:0] r_fetch_count;
  logic [7:0]  r_flush_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_count <= '0;
      r_flush_count <= '0;
    end else begin
      if (r_valid && bus.instr_ready) r_fetch_count <= r_fetch_count + 16'd1;
      // A HOLD instruction accepted in the redirect cycle is consumed, not flushed.
      if (i_branch_valid && ((r_state == WAIT) || (r_state == HOLD && !bus.instr_ready))
          && (r_flush_count != '1))
        r_flush_count <= r_flush_count + 8'd1;
    end
  end

  assign o_fetch_count = r_fetch_count;
  assign o_flush_count = r_flush_count;
`endif

  assign bus.im_req      = (r_state == REQ);
  assign bus.im_addr     = r_pc;
  assign bus.instr_valid = r_valid;
  assign bus.instr_out   = r_instr;
  assign bus.instr_pc    = r_instr_pc;
  assign o_pc_out        = r_pc;
  assign o_busy          = (r_state != IDLE);
  assign o_pc_wrap       = r_wrap;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: two instances (MEM_LAT 1 and 3) share stimulus and are compared
// every cycle against a transaction-level reference model with a fixed-latency memory.
module tb_fetch_sequencer;

  localparam int NI = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       run, ready, br;
  logic [7:0] tgt;

  always #5 clk = ~clk;

  function automatic int lat(int i);
    return (i == 0) ? 1 : 3;
  endfunction

  logic        w_req   [NI];
  logic [7:0]  w_addr  [NI];
  logic        w_valid [NI];
  logic [31:0] w_instr [NI];
  logic [7:0]  w_ipc   [NI];
  logic [7:0]  w_pc    [NI];
  logic        w_busy  [NI];
  logic        w_wrap  [NI];
  logic [31:0] w_rdata [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    fetch_sequencer_if #(.ADDR_W(8), .INSTR_W(32)) bus ();

    fetch_sequencer #(
      .ADDR_W(8), .INSTR_W(32), .MEM_LAT((g == 0) ? 1 : 3),
      .RESET_PC(8'h10), .PC_STEP(1)
    ) dut (
      .clk(clk), .rst_n(rst_n), .i_run(run), .i_branch_valid(br),
      .i_branch_target(tgt), .bus(bus), .o_pc_out(w_pc[g]),
      .o_busy(w_busy[g]), .o_pc_wrap(w_wrap[g])
    );

    assign bus.im_rdata    = w_rdata[g];
    assign bus.instr_ready = ready;
    assign w_req[g]        = bus.im_req;
    assign w_addr[g]       = bus.im_addr;
    assign w_valid[g]      = bus.instr_valid;
    assign w_instr[g]      = bus.instr_out;
    assign w_ipc[g]        = bus.instr_pc;
  end

  // Instruction memory: data for a request appears exactly lat cycles later, junk otherwise.
  logic [31:0] mem [256];
  logic        pv [NI][3];
  logic [7:0]  pa [NI][3];
  logic [31:0] junk;

  always @(posedge clk) begin
    junk <= $urandom;
    for (int i = 0; i < NI; i++) begin
      for (int k = 2; k > 0; k--) begin
        pv[i][k] <= pv[i][k-1];
        pa[i][k] <= pa[i][k-1];
      end
      pv[i][0] <= w_req[i];
      pa[i][0] <= w_addr[i];
    end
  end

  always_comb begin
    for (int i = 0; i < NI; i++) begin
      w_rdata[i] = junk;
      if (pv[i][lat(i)-1] === 1'b1) w_rdata[i] = mem[pa[i][lat(i)-1]];
    end
  end

  // Reference model: busy flag, age of the outstanding request (-1 = none), presented instruction.
  typedef struct {
    logic        busy;
    int          age;
    logic [7:0]  pc;
    logic        iv;
    logic [31:0] instr;
    logic [7:0]  ipc;
    logic        wrap;
  } mdl_t;

  localparam mdl_t MDL_RST = '{busy: 1'b0, age: -1, pc: 8'h10, iv: 1'b0,
                               instr: 32'h0, ipc: 8'h0, wrap: 1'b0};

  mdl_t m [NI];

  function automatic mdl_t mstep(mdl_t c, int l, logic run_i, logic rdy, logic b,
                                 logic [7:0] t, logic [31:0] memv);
    mdl_t n = c;
    n.wrap = 1'b0;
    if (b) begin
      n.pc = t; n.iv = 1'b0; n.age = -1; n.busy = run_i;
    end else if (!c.busy) begin
      n.busy = run_i;
    end else if (!c.iv && c.age < 0) begin
      n.age = 1;
    end else if (c.age > 0) begin
      if (c.age == l) begin
        n.instr = memv; n.ipc = c.pc; n.iv = 1'b1; n.age = -1;
      end else begin
        n.age = c.age + 1;
      end
    end else if (c.iv && rdy) begin
      {n.wrap, n.pc} = {1'b0, c.pc} + 9'd1;
      n.iv = 1'b0;
      n.busy = run_i;
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NI; i++) m[i] <= MDL_RST;
    end else begin
      for (int i = 0; i < NI; i++)
        m[i] <= mstep(m[i], lat(i), run, ready, br, tgt, mem[m[i].pc]);
    end
  end

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  task automatic chk(string ph, int i, string nm, logic [31:0] act, logic [31:0] exp);
    n_total++;
    assert (act === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s lat%0d %s: got %0h expected %0h", ph, lat(i), nm, act, exp);
    end
  endtask

  task automatic check_all(string ph);
    for (int i = 0; i < NI; i++) begin
      chk(ph, i, "im_req",      32'(w_req[i]),   32'(m[i].busy && !m[i].iv && m[i].age < 0));
      chk(ph, i, "im_addr",     32'(w_addr[i]),  32'(m[i].pc));
      chk(ph, i, "instr_valid", 32'(w_valid[i]), 32'(m[i].iv));
      chk(ph, i, "instr_out",   w_instr[i],      m[i].instr);
      chk(ph, i, "instr_pc",    32'(w_ipc[i]),   32'(m[i].ipc));
      chk(ph, i, "pc_out",      32'(w_pc[i]),    32'(m[i].pc));
      chk(ph, i, "busy",        32'(w_busy[i]),  32'(m[i].busy));
      chk(ph, i, "pc_wrap",     32'(w_wrap[i]),  32'(m[i].wrap));
    end
  endtask

  task automatic step(string ph);
    @(posedge clk);
    @(negedge clk);
    check_all(ph);
  endtask

  initial begin
    for (int a = 0; a < 256; a++) mem[a] = (a < 'h20) ? 32'h100 + 32'(a) : $urandom;
    run = 1'b0; ready = 1'b0; br = 1'b0; tgt = 8'h00;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #3 check_all("reset");
    repeat (2) @(negedge clk);
    check_all("reset_hold");

    rst_n = 1'b1; run = 1'b1; ready = 1'b1;
    repeat (14) step("stream");

    ready = 1'b0;
    repeat (8) step("stall");
    ready = 1'b1;
    repeat (4) step("release");

    // Branches landing in every phase, including same-cycle accept + redirect.
    for (int off = 0; off < 8; off++) begin
      repeat (off) step("pre_branch");
      br = 1'b1; tgt = (off % 2 == 0) ? 8'h40 : 8'h80;
      step("branch");
      br = 1'b0;
    end

    br = 1'b1; tgt = 8'hFE;
    step("to_wrap");
    br = 1'b0;
    repeat (18) step("wrap");

    // run dropped mid-fetch: instruction still delivered, then idle.
    for (int off = 1; off < 4; off++) begin
      repeat (off) step("run_on");
      run = 1'b0;
      repeat (8) step("run_off");
      run = 1'b1;
    end

    run = 1'b0;
    repeat (6) step("idle");
    br = 1'b1; tgt = 8'h33;
    step("idle_branch");
    br = 1'b0;
    step("idle_after");
    run = 1'b1;

    // Asynchronous reset at varying points inside a fetch.
    for (int off = 1; off < 5; off++) begin
      repeat (off) step("pre_rst");
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1 check_all("async_rst");
      @(negedge clk);
      check_all("rst_held");
      rst_n = 1'b1;
      repeat (6) step("post_rst");
    end

    repeat (400) begin
      run   = ($urandom_range(0, 9) != 0);
      ready = ($urandom_range(0, 9) < 7);
      br    = ($urandom_range(0, 19) == 0);
      tgt   = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
      step("random");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Sequences instruction fetch for the single-cycle/multi-cycle CPU datapath.
- Owns the program counter and issues one read at a time to the instruction memory (8-bit address, fixed read latency).
- Latches the returned word into an instruction register and hands it to decode over a valid/ready handshake.
- Applies branch redirects and discards any in-flight fetch.

Parameters:
- ADDR_W, 8, PC / instruction-memory address width
- INSTR_W, 32, instruction word width
- MEM_LAT, 1, cycles from request cycle to the cycle im_rdata is valid; legal range 1..7
- RESET_PC, 0, PC value loaded on reset
- PC_STEP, 1, PC increment per accepted instruction (word addressing)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- run  in  1  fetch enable; level-sensitive
- im_req  out  1  read strobe to instruction memory, one cycle per fetch
- im_addr  out  ADDR_W  read address; equals pc_out
- im_rdata  in  INSTR_W  read data from instruction memory
- instr_valid  out  1  instr_out holds an unconsumed instruction
- instr_ready  in  1  decode accepts instr_out
- instr_out  out  INSTR_W  instruction register
- instr_pc  out  ADDR_W  address instr_out was fetched from
- branch_valid  in  1  one-cycle redirect request
- branch_target  in  ADDR_W  redirect address
- pc_out  out  ADDR_W  current fetch PC
- busy  out  1  state != IDLE
- pc_wrap  out  1  one-cycle pulse when PC increments from all-ones to 0

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, pc_out=RESET_PC.
  - instr_out=0, instr_pc=0, instr_valid=0, im_req=0, pc_wrap=0, wait counter=0.
  - Takes effect immediately, mid-fetch included. The in-flight read is abandoned; no instruction is presented after release.
- States:
  - IDLE: im_req=0. If run=1, go to REQ next cycle.
  - REQ: im_req=1 and im_addr=pc_out for exactly one cycle. Load wait counter with MEM_LAT-1 and go to WAIT.
  - WAIT: decrement the counter each cycle. In the cycle the counter is 0, im_rdata is valid. On that edge, capture im_rdata into instr_out and pc_out into instr_pc, set instr_valid=1, and go to HOLD.
  - HOLD: instr_valid=1. If instr_ready=1:
    - pc_out <= pc_out+PC_STEP (mod 2^ADDR_W) and instr_valid <= 0.
    - Next state is REQ if run=1, else IDLE.
- Latency and throughput: with MEM_LAT=1 and ready held high, the request is issued in cycle c, instr_valid rises at c+2, and the next request is issued at c+3. One outstanding request at most; there is no pipelining.
- Branch (branch_valid=1) has top priority in every state:
  - pc_out <= branch_target and instr_valid <= 0.
  - Any WAIT fetch is discarded: its data is never captured and the wait counter is cleared.
  - Next state is REQ if run=1, else IDLE.
  - In IDLE with run=0, the PC updates and the state stays IDLE.
- Branch and handshake in the same cycle (instr_valid=1, instr_ready=1, branch_valid=1): the presented instruction counts as consumed. Next PC = branch_target; PC_STEP is not added and pc_wrap is not pulsed.
- run deasserted in REQ/WAIT: the fetch completes and is held in HOLD. After acceptance the state goes to IDLE with the PC already incremented.
- While instr_valid=1 and instr_ready=0, instr_out and instr_pc stay stable.
- Wrap-around: an increment from 2^ADDR_W-1 yields 0 and pulses pc_wrap for one cycle. A branch never pulses pc_wrap.
- All outputs are registered except im_req, im_addr and busy, which are decoded from state and pc_out.

Optional Feature:
- Macro FETCH_PERF_COUNT_EN.
- When defined:
  - Adds output fetch_count [15:0], reset to 0.
  - Increments by 1 on each accepted instruction (instr_valid && instr_ready), wraps modulo 2^16.
  - Adds output flush_count [7:0], which increments on each branch that discards a WAIT or HOLD instruction and saturates at 255.
- When undefined: neither port exists and no counter logic is built.

Test Plan:
- Reset release with RESET_PC=0x10, MEM_LAT=1, run=1, ready=1, memory returning addr+0x100 -> im_req pulses at 0x10,0x11,0x12 every 3 cycles; instr_out=0x110,0x111,0x112; instr_pc matches.
- ready held 0 for 5 cycles in HOLD -> instr_valid stays 1, instr_out/pc stable, no new im_req; ready=1 -> PC advances by 1, next im_req one cycle later.
- branch_valid with target 0x40 during WAIT (MEM_LAT=3) -> stale data never appears; next im_req has addr 0x40; instr_pc=0x40.
- Same-cycle accept + branch to 0x80 from pc 0x22 -> instruction consumed once (fetch_count +1 if enabled); next request 0x80, not 0x23.
- PC at 0xFF accepted -> pc_out=0x00, pc_wrap one-cycle pulse; run=0 asserted in WAIT -> instruction still delivered, then busy=0, PC=next.
- rst_n asserted asynchronously mid-WAIT -> all outputs clear without a clock edge; after release, first im_req is at RESET_PC.
